// File: rtl/cplx_pingpong_bank_pkg.sv
// Shared defaults and types for the ping-pong complex operand store.
package cplx_pingpong_bank_pkg;

   localparam int DEF_WORD_LEN   = 16;
   localparam int DEF_MATRIX_DIM = 4;

   // Elements loaded per bank: all of M1 followed by all of M2.
   function automatic int elems_per_bank(input int dim);
      return 2 * dim * dim;
   endfunction

   localparam int ELEMS_PER_BANK = elems_per_bank(DEF_MATRIX_DIM);

   typedef enum logic {
      MAT_M1 = 1'b0,
      MAT_M2 = 1'b1
   } mat_sel_t;

endpackage

// File: rtl/cplx_row_bank.sv
// One bank of register storage for M1 and M2 (real and imaginary planes).
// It has a single-element write port and a combinational read of one whole row.
module cplx_row_bank
   import cplx_pingpong_bank_pkg::*;
#(
   parameter int WORD_LEN   = DEF_WORD_LEN,
   parameter int MATRIX_DIM = DEF_MATRIX_DIM,
   parameter int ROW_BITS   = $clog2(MATRIX_DIM)
) (
   input  logic                           clk,
   input  logic                           we,
   input  mat_sel_t                       wr_mat,
   input  logic [ROW_BITS-1:0]            wr_row,
   input  logic [ROW_BITS-1:0]            wr_col,
   input  logic [WORD_LEN-1:0]            wr_real,
   input  logic [WORD_LEN-1:0]            wr_imag,
   input  logic [ROW_BITS-1:0]            rd_row,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m1_real_row,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m1_imag_row,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m2_real_row,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m2_imag_row
);

   logic [WORD_LEN-1:0] m1_re [MATRIX_DIM][MATRIX_DIM];
   logic [WORD_LEN-1:0] m1_im [MATRIX_DIM][MATRIX_DIM];
   logic [WORD_LEN-1:0] m2_re [MATRIX_DIM][MATRIX_DIM];
   logic [WORD_LEN-1:0] m2_im [MATRIX_DIM][MATRIX_DIM];

   // Operand storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         if (wr_mat == MAT_M1) begin
            m1_re[wr_row][wr_col] <= wr_real;
            m1_im[wr_row][wr_col] <= wr_imag;
         end else begin
            m2_re[wr_row][wr_col] <= wr_real;
            m2_im[wr_row][wr_col] <= wr_imag;
         end
      end
   end

   always_comb begin
      m1_real_row = '0;
      m1_imag_row = '0;
      m2_real_row = '0;
      m2_imag_row = '0;
      for (int c = 0; c < MATRIX_DIM; c++) begin
         m1_real_row[c*WORD_LEN +: WORD_LEN] = m1_re[rd_row][c];
         m1_imag_row[c*WORD_LEN +: WORD_LEN] = m1_im[rd_row][c];
         m2_real_row[c*WORD_LEN +: WORD_LEN] = m2_re[rd_row][c];
         m2_imag_row[c*WORD_LEN +: WORD_LEN] = m2_im[rd_row][c];
      end
   end

endmodule

// File: rtl/cplx_pingpong_bank.sv
// Double-buffered complex operand store: a loader fills one bank while rows are read from the other.
// Optional macro CPLX_BANK_M2_TRANSPOSE_EN stores M2 transposed, so each read returns a column of M2.
module cplx_pingpong_bank
   import cplx_pingpong_bank_pkg::*;
#(
   parameter  int WORD_LEN   = DEF_WORD_LEN,
   parameter  int MATRIX_DIM = DEF_MATRIX_DIM,
   localparam int ROW_BITS   = $clog2(MATRIX_DIM)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [WORD_LEN-1:0]            wr_real,
   input  logic [WORD_LEN-1:0]            wr_imag,
   output logic                           wr_done,
   output logic                           rd_bank_full,
   input  logic                           rd_en,
   input  logic [ROW_BITS-1:0]            rd_row,
   input  logic                           rd_release,
   output logic                           rd_valid,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m1_real_row,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m1_imag_row,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m2_real_row,
   output logic [WORD_LEN*MATRIX_DIM-1:0] m2_imag_row,
   output logic                           wr_bank_id,
   output logic                           rd_bank_id
);

   localparam int ELEMS = elems_per_bank(MATRIX_DIM);
   localparam int KB    = $clog2(ELEMS);
   localparam int RW    = WORD_LEN * MATRIX_DIM;

   localparam logic [KB-1:0] K_HALF = KB'(MATRIX_DIM * MATRIX_DIM);
   localparam logic [KB-1:0] K_LAST = KB'(ELEMS - 1);
   localparam logic [KB-1:0] K_DIM  = KB'(MATRIX_DIM);

   logic [KB-1:0]       k;
   logic [KB-1:0]       idx;
   logic [1:0]          full;
   logic [1:0]          bank_we;
   logic                accept;
   logic                last;
   logic                rel;
   logic                rd_fire;
   mat_sel_t            mat;
   logic [ROW_BITS-1:0] ld_row;
   logic [ROW_BITS-1:0] ld_col;
   logic [ROW_BITS-1:0] pos_row;
   logic [ROW_BITS-1:0] pos_col;

   logic [RW-1:0] bk_m1_re [2];
   logic [RW-1:0] bk_m1_im [2];
   logic [RW-1:0] bk_m2_re [2];
   logic [RW-1:0] bk_m2_im [2];

   assign wr_ready     = ~full[wr_bank_id];
   assign rd_bank_full = full[rd_bank_id];
   assign accept       = wr_valid & wr_ready;
   assign last         = (k == K_LAST);
   assign rel          = rd_release & full[rd_bank_id];
   assign rd_fire      = rd_en & full[rd_bank_id];
   assign bank_we      = {accept & wr_bank_id, accept & ~wr_bank_id};

   always_comb begin
      mat    = (k < K_HALF) ? MAT_M1 : MAT_M2;
      idx    = (mat == MAT_M1) ? k : (k - K_HALF);
      ld_row = ROW_BITS'(idx / K_DIM);
      ld_col = ROW_BITS'(idx % K_DIM);
`ifdef CPLX_BANK_M2_TRANSPOSE_EN
      pos_row = (mat == MAT_M2) ? ld_col : ld_row;
      pos_col = (mat == MAT_M2) ? ld_row : ld_col;
`else
      pos_row = ld_row;
      pos_col = ld_col;
`endif
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      cplx_row_bank #(
         .WORD_LEN   (WORD_LEN),
         .MATRIX_DIM (MATRIX_DIM),
         .ROW_BITS   (ROW_BITS)
      ) u_bank (
         .clk         (clk),
         .we          (bank_we[b]),
         .wr_mat      (mat),
         .wr_row      (pos_row),
         .wr_col      (pos_col),
         .wr_real     (wr_real),
         .wr_imag     (wr_imag),
         .rd_row      (rd_row),
         .m1_real_row (bk_m1_re[b]),
         .m1_imag_row (bk_m1_im[b]),
         .m2_real_row (bk_m2_re[b]),
         .m2_imag_row (bk_m2_im[b])
      );
   end

   // A write only ever targets a non-full bank and a release only a full one,
   // so the two full-flag updates below never collide on the same bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k           <= '0;
         full        <= '0;
         wr_bank_id  <= 1'b0;
         rd_bank_id  <= 1'b0;
         wr_done     <= 1'b0;
         rd_valid    <= 1'b0;
         m1_real_row <= '0;
         m1_imag_row <= '0;
         m2_real_row <= '0;
         m2_imag_row <= '0;
      end else begin
         wr_done  <= accept & last;
         rd_valid <= rd_fire;
         if (accept) begin
            if (last) begin
               k                <= '0;
               full[wr_bank_id] <= 1'b1;
               wr_bank_id       <= ~wr_bank_id;
            end else begin
               k <= k + 1'b1;
            end
         end
         if (rel) begin
            full[rd_bank_id] <= 1'b0;
            rd_bank_id       <= ~rd_bank_id;
         end
         if (rd_fire) begin
            m1_real_row <= bk_m1_re[rd_bank_id];
            m1_imag_row <= bk_m1_im[rd_bank_id];
            m2_real_row <= bk_m2_re[rd_bank_id];
            m2_imag_row <= bk_m2_im[rd_bank_id];
         end
      end
   end

endmodule

// File: tb/tb_cplx_pingpong_bank.sv
// Self-checking bench for cplx_pingpong_bank (D=4, WORD_LEN=16) with a row-read scoreboard.
module tb_cplx_pingpong_bank;

   localparam int D  = 4;
   localparam int W  = 16;
   localparam int RW = W * D;

   typedef struct {
      logic [RW-1:0] m1r;
      logic [RW-1:0] m1i;
      logic [RW-1:0] m2r;
      logic [RW-1:0] m2i;
   } row_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [W-1:0]  wr_real = '0;
   logic [W-1:0]  wr_imag = '0;
   logic          wr_done;
   logic          rd_bank_full;
   logic          rd_en = 1'b0;
   logic [1:0]    rd_row = '0;
   logic          rd_release = 1'b0;
   logic          rd_valid;
   logic [RW-1:0] m1_real_row, m1_imag_row, m2_real_row, m2_imag_row;
   logic          wr_bank_id, rd_bank_id;

   cplx_pingpong_bank #(.WORD_LEN(W), .MATRIX_DIM(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_real      (wr_real),
      .wr_imag      (wr_imag),
      .wr_done      (wr_done),
      .rd_bank_full (rd_bank_full),
      .rd_en        (rd_en),
      .rd_row       (rd_row),
      .rd_release   (rd_release),
      .rd_valid     (rd_valid),
      .m1_real_row  (m1_real_row),
      .m1_imag_row  (m1_imag_row),
      .m2_real_row  (m2_real_row),
      .m2_imag_row  (m2_imag_row),
      .wr_bank_id   (wr_bank_id),
      .rd_bank_id   (rd_bank_id)
   );

   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;

   // Reference model of the block state, stepped alongside each clock edge.
   int   m_re [2][2][D][D];
   int   m_im [2][2][D][D];
   bit   m_full [2];
   bit   m_wb, m_rb, m_valid, m_done;
   int   m_k;
   row_t sb [$];
   row_t exp_row, last_exp;

   task automatic model_reset();
      m_full[0] = 0; m_full[1] = 0;
      m_wb = 0; m_rb = 0; m_k = 0; m_valid = 0; m_done = 0;
      sb.delete();
      last_exp.m1r = '0; last_exp.m1i = '0; last_exp.m2r = '0; last_exp.m2i = '0;
   endtask

   task automatic cycle();
      bit   acc, rel, fire;
      int   mat, idx;
      row_t e;
      acc  = wr_valid && !m_full[m_wb];
      rel  = rd_release && m_full[m_rb];
      fire = rd_en && m_full[m_rb];
      if (fire) begin
         for (int c = 0; c < D; c++) begin
            e.m1r[c*W +: W] = W'(m_re[m_rb][0][rd_row][c]);
            e.m1i[c*W +: W] = W'(m_im[m_rb][0][rd_row][c]);
`ifdef CPLX_BANK_M2_TRANSPOSE_EN
            e.m2r[c*W +: W] = W'(m_re[m_rb][1][c][rd_row]);
            e.m2i[c*W +: W] = W'(m_im[m_rb][1][c][rd_row]);
`else
            e.m2r[c*W +: W] = W'(m_re[m_rb][1][rd_row][c]);
            e.m2i[c*W +: W] = W'(m_im[m_rb][1][rd_row][c]);
`endif
         end
         sb.push_back(e);
      end
      m_done = 0;
      if (acc) begin
         mat = (m_k >= D*D) ? 1 : 0;
         idx = m_k - mat*D*D;
         m_re[m_wb][mat][idx/D][idx%D] = int'($signed(wr_real));
         m_im[m_wb][mat][idx/D][idx%D] = int'($signed(wr_imag));
         if (m_k == 2*D*D-1) begin
            m_full[m_wb] = 1; m_wb = ~m_wb; m_k = 0; m_done = 1;
         end else begin
            m_k++;
         end
      end
      if (rel) begin
         m_full[m_rb] = 0; m_rb = ~m_rb;
      end
      m_valid = fire;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_elem(input int v);
      wr_valid = 1'b1;
      wr_real  = W'(v);
      wr_imag  = W'(-v);
   endtask

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         drive_elem(base + i);
         cycle();
      end
      wr_valid = 1'b0;
   endtask

   task automatic read_row(input int row);
      rd_en  = 1'b1;
      rd_row = 2'(row);
      cycle();
      rd_en  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      n_assert++;
      if ({wr_ready, wr_done, rd_bank_full, rd_valid, wr_bank_id, rd_bank_id} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 100000",
                  {wr_ready, wr_done, rd_bank_full, rd_valid, wr_bank_id, rd_bank_id});
      end
      n_assert++;
      if ({m1_real_row, m1_imag_row, m2_real_row, m2_imag_row} !== '0) begin
         n_fail++;
         $display("FAIL reset_rows: got %h expected 0", {m1_real_row, m1_imag_row, m2_real_row, m2_imag_row});
      end
      #2 rst = 1'b0;
   endtask

   task automatic test_first_load();
      load(0, 2*D*D-1);
      n_assert++;
      if (wr_done !== 1'b0 || rd_bank_full !== 1'b0) begin
         n_fail++;
         $display("FAIL early_done: got done=%b full=%b expected 0 0", wr_done, rd_bank_full);
      end
      drive_elem(2*D*D-1);
      cycle();
      wr_valid = 1'b0;
      n_assert++;
      if (wr_done !== 1'b1 || rd_bank_full !== 1'b1 || wr_bank_id !== 1'b1) begin
         n_fail++;
         $display("FAIL first_done: got done=%b full=%b wb=%b expected 1 1 1", wr_done, rd_bank_full, wr_bank_id);
      end
      cycle();
      n_assert++;
      if (wr_done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: got %b expected 0", wr_done);
      end
      for (int r = 2; r >= 0; r--) begin
         read_row(r);
         n_assert++;
         if (rd_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL first_rd_valid: got valid=%b sb=%0d expected 1", rd_valid, sb.size());
         end else begin
            exp_row = sb.pop_front();
            last_exp = exp_row;
            n_assert++;
            if (m1_real_row !== exp_row.m1r || m1_imag_row !== exp_row.m1i ||
                m2_real_row !== exp_row.m2r || m2_imag_row !== exp_row.m2i) begin
               n_fail++;
               $display("FAIL first_row%0d: got %h %h %h %h expected %h %h %h %h", r,
                        m1_real_row, m1_imag_row, m2_real_row, m2_imag_row,
                        exp_row.m1r, exp_row.m1i, exp_row.m2r, exp_row.m2i);
            end
         end
         if (r == 2) begin
            n_assert++;
            if (m1_real_row !== {16'd11, 16'd10, 16'd9, 16'd8} ||
                m1_imag_row !== {16'hfff5, 16'hfff6, 16'hfff7, 16'hfff8}) begin
               n_fail++;
               $display("FAIL row2_m1_const: got %h %h", m1_real_row, m1_imag_row);
            end
`ifndef CPLX_BANK_M2_TRANSPOSE_EN
            n_assert++;
            if (m2_real_row !== {16'd27, 16'd26, 16'd25, 16'd24}) begin
               n_fail++;
               $display("FAIL row2_m2_const: got %h expected 001b001a00190018", m2_real_row);
            end
`endif
         end
`ifdef CPLX_BANK_M2_TRANSPOSE_EN
         if (r == 1) begin
            n_assert++;
            if (m2_real_row !== {16'd29, 16'd25, 16'd21, 16'd17}) begin
               n_fail++;
               $display("FAIL row1_m2_transpose: got %h expected 001d001900150011", m2_real_row);
            end
         end
`endif
      end
   endtask

   task automatic test_both_full();
      load(100, 2*D*D);
      n_assert++;
      if (wr_done !== 1'b1 || wr_ready !== 1'b0 || wr_bank_id !== 1'b0) begin
         n_fail++;
         $display("FAIL both_full: got done=%b ready=%b wb=%b expected 1 0 0", wr_done, wr_ready, wr_bank_id);
      end
      for (int i = 0; i < 3; i++) begin
         drive_elem(900 + i);
         cycle();
         n_assert++;
         if (wr_ready !== 1'b0 || wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL blocked_%0d: got ready=%b done=%b expected 0 0", i, wr_ready, wr_done);
         end
      end
      wr_valid = 1'b0;
   endtask

   task automatic test_release_with_read();
      rd_release = 1'b1;
      read_row(0);
      rd_release = 1'b0;
      n_assert++;
      if (rd_valid !== 1'b1 || sb.size() == 0) begin
         n_fail++;
         $display("FAIL relrd_valid: got %b expected 1", rd_valid);
      end else begin
         exp_row = sb.pop_front();
         last_exp = exp_row;
         n_assert++;
         if (m1_real_row !== exp_row.m1r || m2_imag_row !== exp_row.m2i ||
             m1_real_row !== {16'd3, 16'd2, 16'd1, 16'd0}) begin
            n_fail++;
            $display("FAIL relrd_data: got %h %h expected %h %h", m1_real_row, m2_imag_row, exp_row.m1r, exp_row.m2i);
         end
      end
      n_assert++;
      if (rd_bank_id !== 1'b1 || wr_ready !== 1'b1 || rd_bank_full !== 1'b1) begin
         n_fail++;
         $display("FAIL relrd_swap: got rb=%b ready=%b full=%b expected 1 1 1", rd_bank_id, wr_ready, rd_bank_full);
      end
   endtask

   task automatic test_simultaneous();
      load(200, 2*D*D-1);
      drive_elem(200 + 2*D*D-1);
      rd_release = 1'b1;
      cycle();
      wr_valid = 1'b0;
      rd_release = 1'b0;
      n_assert++;
      if (wr_done !== 1'b1 || wr_bank_id !== m_wb || rd_bank_id !== m_rb ||
          rd_bank_full !== 1'b1 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL simul: got done=%b wb=%b rb=%b full=%b ready=%b expected 1 %b %b 1 1",
                  wr_done, wr_bank_id, rd_bank_id, rd_bank_full, wr_ready, m_wb, m_rb);
      end
      for (int r = 1; r < D; r += 2) begin
         read_row(r);
         n_assert++;
         if (rd_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL simul_rd_valid: got %b expected 1", rd_valid);
         end else begin
            exp_row = sb.pop_front();
            last_exp = exp_row;
            n_assert++;
            if (m1_real_row !== exp_row.m1r || m1_imag_row !== exp_row.m1i ||
                m2_real_row !== exp_row.m2r || m2_imag_row !== exp_row.m2i) begin
               n_fail++;
               $display("FAIL simul_row%0d: got %h %h expected %h %h", r,
                        m1_real_row, m2_real_row, exp_row.m1r, exp_row.m2r);
            end
         end
      end
   endtask

   task automatic test_release_empty();
      rd_release = 1'b1;
      cycle();
      n_assert++;
      if (rd_bank_id !== 1'b1 || rd_bank_full !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_to_empty: got rb=%b full=%b expected 1 0", rd_bank_id, rd_bank_full);
      end
      rd_row = 2'd2;
      rd_en  = 1'b1;
      cycle();
      cycle();
      rd_en = 1'b0;
      rd_release = 1'b0;
      n_assert++;
      if (rd_valid !== 1'b0 || rd_bank_id !== 1'b1 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL empty_ignored: got valid=%b rb=%b sb=%0d expected 0 1 0", rd_valid, rd_bank_id, sb.size());
      end
      n_assert++;
      if (m1_real_row !== last_exp.m1r || m1_imag_row !== last_exp.m1i ||
          m2_real_row !== last_exp.m2r || m2_imag_row !== last_exp.m2i) begin
         n_fail++;
         $display("FAIL empty_hold: got %h %h expected %h %h", m1_real_row, m2_real_row, last_exp.m1r, last_exp.m2r);
      end
   endtask

   task automatic test_reset_mid_load();
      load(500, 10);
      #2 rst = 1'b1;
      model_reset();
      #2;
      n_assert++;
      if (wr_bank_id !== 1'b0 || rd_bank_id !== 1'b0 || rd_bank_full !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst: got wb=%b rb=%b full=%b ready=%b expected 0 0 0 1",
                  wr_bank_id, rd_bank_id, rd_bank_full, wr_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      load(300, 2*D*D-1);
      n_assert++;
      if (rd_bank_full !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_31: got full=%b expected 0", rd_bank_full);
      end
      load(300 + 2*D*D-1, 1);
      n_assert++;
      if (rd_bank_full !== 1'b1 || wr_done !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_32: got full=%b done=%b expected 1 1", rd_bank_full, wr_done);
      end
      read_row(0);
      n_assert++;
      if (rd_valid !== 1'b1 || sb.size() == 0) begin
         n_fail++;
         $display("FAIL midrst_rd_valid: got %b expected 1", rd_valid);
      end else begin
         exp_row = sb.pop_front();
         n_assert++;
         if (m1_real_row !== exp_row.m1r || m1_imag_row !== exp_row.m1i ||
             m2_real_row !== exp_row.m2r || m2_imag_row !== exp_row.m2i ||
             m1_real_row[W-1:0] !== 16'd300) begin
            n_fail++;
            $display("FAIL midrst_row0: got %h %h expected %h %h", m1_real_row, m2_real_row, exp_row.m1r, exp_row.m2r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_both_full();
      test_release_with_read();
      test_simultaneous();
      test_release_empty();
      test_reset_mid_load();
      n_assert++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
